// File: rtl/mem_align32.sv
// Byte-addressed access adapter for a 32-bit word SPRAM. Word-crossing accesses
// become two bus cycles, and read data is merged across the 1-cycle read latency.
module mem_align32 #(
    parameter int AW = 17,
    parameter int WW = 15
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req,
    input  logic          we,
    input  logic [1:0]    size,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic          ack,
    output logic          err,
    output logic [31:0]   rdata,
    output logic          busy,
    output logic [WW-1:0] mem_ai,
    output logic [31:0]   mem_vi,
    output logic          mem_we,
    output logic [3:0]    mem_bmsk,
    input  logic [31:0]   mem_vo
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_A0   = 3'd1;
    localparam logic [2:0] S_A1   = 3'd2;
    localparam logic [2:0] S_RD   = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;
    localparam logic [2:0] S_ERR  = 3'd5;

    logic [2:0]    r_state;
    logic [2:0]    w_next;
    logic          r_we;
    logic [1:0]    r_size;
    logic [1:0]    r_off;
    logic [WW-1:0] r_ai;
    logic [31:0]   r_vi;
    logic [31:0]   r_w0;
    logic [31:0]   r_rdata;

    logic [3:0]    w_mask;
    logic [7:0]    w_span;
    logic          w_split;
    logic [4:0]    w_sh_in;
    logic [31:0]   w_rot;
    logic [31:0]   w_bytes;
    logic [63:0]   w_pair;
    logic [31:0]   w_rd;

    function automatic logic [3:0] lane_mask(input logic [1:0] sz);
        case (sz)
            2'd0:    lane_mask = 4'b0001;
            2'd1:    lane_mask = 4'b0011;
            2'd2:    lane_mask = 4'b1111;
            default: lane_mask = 4'b0000;
        endcase
    endfunction

    // Lanes of the access spread over two words: [3:0] first word, [7:4] second.
    assign w_mask  = lane_mask(r_size);
    assign w_span  = {4'b0000, w_mask} << r_off;
    assign w_split = |w_span[7:4];

    // Rotate write data so byte i lands on lane (off+i) mod 4; a shift by 32 yields 0.
    assign w_sh_in = {addr[1:0], 3'b000};
    assign w_rot   = (wdata << w_sh_in) | (wdata >> (6'd32 - {1'b0, w_sh_in}));

    assign w_bytes = {{8{w_mask[3]}}, {8{w_mask[2]}}, {8{w_mask[1]}}, {8{w_mask[0]}}};
    assign w_pair  = w_split ? {mem_vo, r_w0} : {32'h0000_0000, mem_vo};
    assign w_rd    = 32'(w_pair >> {r_off, 3'b000}) & w_bytes;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (req) w_next = (size == 2'd3) ? S_ERR : S_A0;
            S_A0: begin
                if (w_split)   w_next = S_A1;
                else if (r_we) w_next = S_DONE;
                else           w_next = S_RD;
            end
            S_A1:    w_next = r_we ? S_DONE : S_RD;
            S_RD:    w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            S_ERR:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_we    <= 1'b0;
            r_size  <= 2'd0;
            r_off   <= 2'd0;
            r_ai    <= '0;
            r_vi    <= 32'h0;
            r_w0    <= 32'h0;
            r_rdata <= 32'h0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE: begin
                    if (req) begin
                        r_we   <= we;
                        r_size <= size;
                        r_off  <= addr[1:0];
                        if (size != 2'd3) begin
                            r_ai <= addr[AW-1:2];
                            if (we) r_vi <= w_rot;
                        end
                    end
                end
                S_A0: if (w_split) r_ai <= r_ai + WW'(1);
                // Cycle after A0 of a split read: first word is on mem_vo.
                S_A1: if (!r_we) r_w0 <= mem_vo;
                S_RD: r_rdata <= w_rd;
                default: ;
            endcase
        end
    end

    assign busy     = (r_state != S_IDLE);
    assign ack      = (r_state == S_DONE) || (r_state == S_ERR);
    assign err      = (r_state == S_ERR);
    assign rdata    = r_rdata;
    assign mem_ai   = r_ai;
    assign mem_vi   = r_vi;
    assign mem_we   = r_we && ((r_state == S_A0) || (r_state == S_A1));
    assign mem_bmsk = (r_state == S_A0) ? w_span[3:0] :
                      (r_state == S_A1) ? w_span[7:4] : 4'b0000;

endmodule

// File: tb/tb_mem_align32.sv
// Bench for mem_align32: SPRAM model, directed table, reset corners, and random
// traffic against a byte-level memory model.
module tb_mem_align32;

    localparam int AW = 17;
    localparam int WW = 15;

    logic          clk;
    logic          rst_n;
    logic          req;
    logic          we;
    logic [1:0]    size;
    logic [AW-1:0] addr;
    logic [31:0]   wdata;
    logic          ack;
    logic          err;
    logic [31:0]   rdata;
    logic          busy;
    logic [WW-1:0] mem_ai;
    logic [31:0]   mem_vi;
    logic          mem_we;
    logic [3:0]    mem_bmsk;
    logic [31:0]   mem_vo;

    int checks   = 0;
    int failures = 0;

    mem_align32 #(.AW(AW), .WW(WW)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .we(we), .size(size), .addr(addr),
        .wdata(wdata), .ack(ack), .err(err), .rdata(rdata), .busy(busy),
        .mem_ai(mem_ai), .mem_vi(mem_vi), .mem_we(mem_we), .mem_bmsk(mem_bmsk),
        .mem_vo(mem_vo)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- SPRAM model (1-cycle read latency) ----------------
    logic [31:0] spram [0:32767] = '{default: 32'h0};
    logic [31:0] lm_spram;
    always_comb lm_spram = {{8{mem_bmsk[3]}}, {8{mem_bmsk[2]}}, {8{mem_bmsk[1]}}, {8{mem_bmsk[0]}}};
    always @(posedge clk) begin
        if (mem_we) spram[mem_ai] <= (spram[mem_ai] & ~lm_spram) | (mem_vi & lm_spram);
        mem_vo <= spram[mem_ai];
    end

    // ---------------- reference model (byte-addressed) ----------------
    logic [7:0]    ref_mem [0:(1<<AW)-1] = '{default: 8'h00};
    logic [31:0]   last_rd = 32'h0;
    int            e_k;
    logic          e_err;
    logic [31:0]   e_rd;
    int            e_n;
    logic [WW-1:0] e_ai [0:1];
    logic [3:0]    e_bm [0:1];
    logic [31:0]   e_vi [0:1];
    logic [31:0]   exp_q [$];

    task automatic predict(input logic i_we, input logic [1:0] i_size,
                           input logic [AW-1:0] i_addr, input logic [31:0] i_wdata);
        int n;
        int l;
        logic [AW-1:0] b;
        logic [WW-1:0] w;
        logic [31:0] rd;
        e_n = 0;
        for (int j = 0; j < 2; j++) begin
            e_ai[j] = '0; e_bm[j] = 4'h0; e_vi[j] = 32'h0;
        end
        if (i_size == 2'd3) begin
            e_err = 1'b1; e_k = 1; e_rd = last_rd;
            return;
        end
        e_err = 1'b0;
        n  = (i_size == 2'd2) ? 4 : int'(i_size) + 1;
        rd = 32'h0;
        for (int i = 0; i < n; i++) begin
            b = i_addr + AW'(i);
            w = b[AW-1:2];
            l = int'(b[1:0]);
            if (e_n == 0 || w != e_ai[e_n-1]) begin
                e_ai[e_n] = w;
                e_n++;
            end
            e_bm[e_n-1][l] = 1'b1;
            e_vi[e_n-1][8*l +: 8] = i_wdata[8*i +: 8];
            if (i_we) ref_mem[b] = i_wdata[8*i +: 8];
            else      rd[8*i +: 8] = ref_mem[b];
        end
        e_k = i_we ? 1 + e_n : 2 + e_n;
        if (!i_we) last_rd = rd;
        e_rd = last_rd;
    endtask

    // ---------------- checker ----------------
    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
        end
    endtask

    function automatic logic [31:0] lanes32(input logic [3:0] bm);
        lanes32 = 32'h0;
        for (int l = 0; l < 4; l++) if (bm[l]) lanes32[8*l +: 8] = 8'hFF;
    endfunction

    // ---------------- driver ----------------
    logic [WW-1:0] b_ai [0:3];
    logic [3:0]    b_bm [0:3];
    logic [31:0]   b_vi [0:3];
    logic          b_we [0:3];
    int            b_n;
    int            t_k;
    logic          t_err;
    logic [31:0]   t_rdata;
    logic          t_busy1;

    task automatic run_txn(input logic i_we, input logic [1:0] i_size,
                           input logic [AW-1:0] i_addr, input logic [31:0] i_wdata,
                           input bit drop);
        b_n = 0; t_k = 0; t_err = 1'b0; t_rdata = 32'h0; t_busy1 = 1'b0;
        @(negedge clk);
        we = i_we; size = i_size; addr = i_addr; wdata = i_wdata; req = 1'b1;
        @(posedge clk);
        #1;
        if (drop) req = 1'b0;
        for (int c = 1; c <= 8 && t_k == 0; c++) begin
            @(negedge clk);
            if (c == 1) t_busy1 = busy;
            if (mem_we || mem_bmsk != 4'h0) begin
                if (b_n < 4) begin
                    b_ai[b_n] = mem_ai; b_bm[b_n] = mem_bmsk;
                    b_vi[b_n] = mem_vi; b_we[b_n] = mem_we;
                end
                b_n++;
            end
            if (ack) begin
                t_k = c; t_err = err; t_rdata = rdata;
            end
        end
        req = 1'b0;
        @(negedge clk);
        chk("ack_one_cycle_then_idle", {29'h0, ack, err, busy}, 32'h0);
    endtask

    task automatic cmp_model(input string tag, input logic i_we);
        chk({tag, "_k"}, 32'(t_k), 32'(e_k));
        chk({tag, "_err"}, 32'(t_err), 32'(e_err));
        chk({tag, "_ncyc"}, 32'(b_n), 32'(e_n));
        chk({tag, "_busy"}, 32'(t_busy1), 32'h1);
        for (int j = 0; j < 2; j++) begin
            if (j < e_n && j < b_n) begin
                chk($sformatf("%s_ai%0d", tag, j), 32'(b_ai[j]), 32'(e_ai[j]));
                chk($sformatf("%s_bm%0d", tag, j), 32'(b_bm[j]), 32'(e_bm[j]));
                chk($sformatf("%s_we%0d", tag, j), 32'(b_we[j]), 32'(i_we));
                if (i_we)
                    chk($sformatf("%s_vi%0d", tag, j), b_vi[j] & lanes32(e_bm[j]), e_vi[j]);
            end
        end
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic          we;
        logic [1:0]    size;
        logic [AW-1:0] addr;
        logic [31:0]   wdata;
        int            exp_k;
        logic          exp_err;
        logic [31:0]   exp_rd;
        int            exp_n;
        logic [WW-1:0] ai0;
        logic [3:0]    bm0;
        logic [WW-1:0] ai1;
        logic [3:0]    bm1;
        logic [31:0]   exp_vi;
    } vec_t;

    localparam int NV = 10;
    vec_t tbl [NV];

    initial begin
        req = 1'b0; we = 1'b0; size = 2'd0; addr = '0; wdata = 32'h0;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        // Async reset must be visible before any clock edge.
        chk("rst_ack",  32'(ack), 32'h0);
        chk("rst_err",  32'(err), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_ai",   32'(mem_ai), 32'h0);
        chk("rst_vi",   mem_vi, 32'h0);
        chk("rst_we",   32'(mem_we), 32'h0);
        chk("rst_bmsk", 32'(mem_bmsk), 32'h0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        //          we    sz    addr       wdata         k  err  rdata        n  ai0      bm0      ai1      bm1      vi
        tbl[0] = '{1'b1, 2'd2, 17'h00004, 32'h11223344, 2, 1'b0, 32'h00000000, 1, 15'h0001, 4'b1111, 15'h0000, 4'b0000, 32'h11223344};
        tbl[1] = '{1'b0, 2'd0, 17'h00006, 32'h00000000, 3, 1'b0, 32'h00000022, 1, 15'h0001, 4'b0100, 15'h0000, 4'b0000, 32'h0};
        tbl[2] = '{1'b0, 2'd1, 17'h00006, 32'h00000000, 3, 1'b0, 32'h00001122, 1, 15'h0001, 4'b1100, 15'h0000, 4'b0000, 32'h0};
        tbl[3] = '{1'b1, 2'd1, 17'h00020, 32'h00005555, 2, 1'b0, 32'h00001122, 1, 15'h0008, 4'b0011, 15'h0000, 4'b0000, 32'h00005555};
        tbl[4] = '{1'b1, 2'd2, 17'h00003, 32'hAABBCCDD, 3, 1'b0, 32'h00001122, 2, 15'h0000, 4'b1000, 15'h0001, 4'b0111, 32'hDDAABBCC};
        tbl[5] = '{1'b0, 2'd2, 17'h00003, 32'h00000000, 4, 1'b0, 32'hAABBCCDD, 2, 15'h0000, 4'b1000, 15'h0001, 4'b0111, 32'h0};
        tbl[6] = '{1'b1, 2'd1, 17'h1FFFF, 32'h0000BEEF, 3, 1'b0, 32'hAABBCCDD, 2, 15'h7FFF, 4'b1000, 15'h0000, 4'b0001, 32'hEF0000BE};
        tbl[7] = '{1'b0, 2'd1, 17'h1FFFF, 32'h00000000, 4, 1'b0, 32'h0000BEEF, 2, 15'h7FFF, 4'b1000, 15'h0000, 4'b0001, 32'h0};
        tbl[8] = '{1'b0, 2'd3, 17'h00010, 32'h00000000, 1, 1'b1, 32'h0000BEEF, 0, 15'h0000, 4'b0000, 15'h0000, 4'b0000, 32'h0};
        tbl[9] = '{1'b0, 2'd0, 17'h00000, 32'h00000000, 3, 1'b0, 32'h000000BE, 1, 15'h0000, 4'b0001, 15'h0000, 4'b0000, 32'h0};

        for (int v = 0; v < NV; v++) begin
            predict(tbl[v].we, tbl[v].size, tbl[v].addr, tbl[v].wdata);
            run_txn(tbl[v].we, tbl[v].size, tbl[v].addr, tbl[v].wdata, 1'b0);
            chk($sformatf("v%0d_k", v), 32'(t_k), 32'(tbl[v].exp_k));
            chk($sformatf("v%0d_err", v), 32'(t_err), 32'(tbl[v].exp_err));
            chk($sformatf("v%0d_rdata", v), t_rdata, tbl[v].exp_rd);
            chk($sformatf("v%0d_ncyc", v), 32'(b_n), 32'(tbl[v].exp_n));
            if (tbl[v].exp_n >= 1 && b_n >= 1) begin
                chk($sformatf("v%0d_ai0", v), 32'(b_ai[0]), 32'(tbl[v].ai0));
                chk($sformatf("v%0d_bm0", v), 32'(b_bm[0]), 32'(tbl[v].bm0));
                chk($sformatf("v%0d_we0", v), 32'(b_we[0]), 32'(tbl[v].we));
                if (tbl[v].we) chk($sformatf("v%0d_vi0", v), b_vi[0], tbl[v].exp_vi);
            end
            if (tbl[v].exp_n >= 2 && b_n >= 2) begin
                chk($sformatf("v%0d_ai1", v), 32'(b_ai[1]), 32'(tbl[v].ai1));
                chk($sformatf("v%0d_bm1", v), 32'(b_bm[1]), 32'(tbl[v].bm1));
                chk($sformatf("v%0d_we1", v), 32'(b_we[1]), 32'(tbl[v].we));
                if (tbl[v].we) chk($sformatf("v%0d_vi1", v), b_vi[1], tbl[v].exp_vi);
            end
        end

        // Reset during A1 of a split write: outputs drop at once, no ack.
        @(negedge clk);
        we = 1'b1; size = 2'd2; addr = 17'h00041; wdata = 32'h01020304; req = 1'b1;
        @(posedge clk); #1;
        chk("mid_a0_we", 32'(mem_we), 32'h1);
        @(posedge clk); #1;
        chk("mid_a1_bmsk", 32'(mem_bmsk), 32'h1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_we",   32'(mem_we), 32'h0);
        chk("mid_rst_bmsk", 32'(mem_bmsk), 32'h0);
        chk("mid_rst_busy", 32'(busy), 32'h0);
        chk("mid_rst_ack",  32'(ack), 32'h0);
        chk("mid_rst_rdata", rdata, 32'h0);
        req = 1'b0;
        @(negedge clk);
        chk("mid_rst_noack", 32'(ack), 32'h0);
        rst_n = 1'b1;
        // Only the first word (bytes 0x41..0x43) reached memory.
        ref_mem[17'h00041] = 8'h04;
        ref_mem[17'h00042] = 8'h03;
        ref_mem[17'h00043] = 8'h02;
        last_rd = 32'h0;
        predict(1'b0, 2'd2, 17'h00040, 32'h0);
        run_txn(1'b0, 2'd2, 17'h00040, 32'h0, 1'b0);
        cmp_model("post_rst_rd0", 1'b0);
        chk("post_rst_rd0_rdata", t_rdata, e_rd);
        predict(1'b0, 2'd2, 17'h00044, 32'h0);
        run_txn(1'b0, 2'd2, 17'h00044, 32'h0, 1'b0);
        cmp_model("post_rst_rd1", 1'b0);
        chk("post_rst_rd1_rdata", t_rdata, e_rd);

        // Random traffic in a low window and a window that wraps past the top.
        for (int r = 0; r < 80; r++) begin
            logic          r_we_v;
            logic [1:0]    r_sz;
            logic [AW-1:0] r_ad;
            logic [31:0]   r_wd;
            int            pick;
            bit            drop;
            r_we_v = 1'($urandom_range(0, 1));
            pick   = $urandom_range(0, 7);
            r_sz   = (pick == 7) ? 2'd3 : 2'(pick % 3);
            r_ad   = ($urandom_range(0, 1) == 0) ? AW'($urandom_range(0, 31))
                                                 : 17'h1FFE0 + AW'($urandom_range(0, 31));
            r_wd   = $urandom;
            drop   = ($urandom_range(0, 3) == 0);
            predict(r_we_v, r_sz, r_ad, r_wd);
            exp_q.push_back(e_rd);
            run_txn(r_we_v, r_sz, r_ad, r_wd, drop);
            cmp_model($sformatf("rnd%0d", r), r_we_v);
            chk($sformatf("rnd%0d_rdata", r), t_rdata, exp_q.pop_front());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
